// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: SOF, LEN, LEN payload bytes, additive checksum.
// Good frames are buffered and replayed on a ready/valid output port.
module uart_frame_parser #(
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SOF          = 8'h7E,
    parameter int          TIMEOUT_CLKS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_good,
    output logic       frame_err,
    output logic [1:0] err_code
);

    // state   | meaning
    // HUNT    | waiting for SOF, everything else ignored
    // LEN     | expecting the length byte
    // PAYLOAD | storing payload bytes, accumulating sum
    // CSUM    | expecting checksum byte
    // DELIVER | replaying buffer to consumer, input bytes are overruns
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DELIVER} state_t;

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TMR_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CLKS - 1);

    state_t           state_q;
    logic [7:0]       len_q;
    logic [7:0]       idx_q;
    logic [7:0]       sum_q;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       mem_q [2**IDX_W];
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;
    logic             frame_good_q;
    logic             frame_err_q;
    logic [1:0]       err_code_q;

    logic [7:0] idx_nxt;
    assign idx_nxt = idx_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            sum_q        <= 8'd0;
            tmr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_last_q   <= 1'b0;
            frame_good_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            frame_good_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
            case (state_q)
                HUNT: begin
                    if (in_valid && in_data == SOF) begin
                        state_q <= LEN;
                        tmr_q   <= TMR_LOAD;
                    end
                end
                LEN, PAYLOAD, CSUM: begin
                    if (in_valid) begin
                        // Any accepted byte restarts the idle window.
                        tmr_q <= TMR_LOAD;
                        if (state_q == LEN) begin
                            if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'd1;
                                state_q     <= HUNT;
                            end else begin
                                len_q   <= in_data;
                                sum_q   <= in_data;
                                idx_q   <= 8'd0;
                                state_q <= PAYLOAD;
                            end
                        end else if (state_q == PAYLOAD) begin
                            mem_q[idx_q[IDX_W-1:0]] <= in_data;
                            sum_q <= sum_q + in_data;
                            if (idx_q == len_q - 8'd1) begin
                                state_q <= CSUM;
                            end else begin
                                idx_q <= idx_nxt;
                            end
                        end else if (in_data == sum_q) begin
                            frame_good_q <= 1'b1;
                            out_valid_q  <= 1'b1;
                            out_data_q   <= mem_q[0];
                            out_last_q   <= (len_q == 8'd1);
                            idx_q        <= 8'd0;
                            state_q      <= DELIVER;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd0;
                            state_q     <= HUNT;
                        end
                    end else if (tmr_q == '0) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'd2;
                        state_q     <= HUNT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                DELIVER: begin
                    if (in_valid) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'd3;
                    end
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= 8'd0;
                            out_last_q  <= 1'b0;
                            idx_q       <= 8'd0;
                            state_q     <= HUNT;
                        end else begin
                            idx_q      <= idx_nxt;
                            out_data_q <= mem_q[idx_nxt[IDX_W-1:0]];
                            out_last_q <= (idx_nxt == len_q - 8'd1);
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_good = frame_good_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload bytes and
// good/error events are queued at stimulus time and matched by a monitor.
module tb_uart_frame_parser;

    localparam int T_CLKS = 64;
    localparam int EV_GOOD = 16;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_good;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    int         evq [$];
    logic [8:0] dq  [$];

    uart_frame_parser #(.MAX_LEN(16), .SOF(8'h7E), .TIMEOUT_CLKS(T_CLKS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_good (frame_good),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: compares every output cycle against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check_eq("out_pending", int'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    check_eq("out_data", int'(out_data), int'(dq[0][7:0]));
                    check_eq("out_last", int'(out_last), int'(dq[0][8]));
                    if (out_ready) void'(dq.pop_front());
                end
            end else begin
                check_eq("idle_out", int'({out_last, out_data}), 0);
            end
            if (frame_good || frame_err) begin
                check_eq("pulse_excl", int'(frame_good && frame_err), 0);
                if (evq.size() > 0)
                    check_eq("event", frame_good ? EV_GOOD : int'(err_code), evq.pop_front());
                else
                    check_eq("event_unexp", frame_good ? EV_GOOD : int'(err_code), -1);
            end else begin
                check_eq("idle_code", int'(err_code), 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // ev: EV_GOOD queues the payload; 0..3 queues an error; -1 queues nothing.
    task automatic send_frame(input bq_t b, input int ev);
        for (int i = 0; i < b.size(); i++) begin
            if (i == b.size() - 1 && ev >= 0) begin
                evq.push_back(ev);
                if (ev == EV_GOOD) begin
                    for (int k = 0; k < int'(b[1]); k++)
                        dq.push_back({(k == int'(b[1]) - 1), b[2 + k]});
                end
            end
            send_byte(b[i]);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (dq.size() == 0 && evq.size() == 0) break;
            @(posedge clk); #1;
        end
        check_eq("drain", dq.size() + evq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_data"},  int'(out_data), 0);
        check_eq({tag, "_last"},  int'(out_last), 0);
        check_eq({tag, "_good"},  int'(frame_good), 0);
        check_eq({tag, "_err"},   int'(frame_err), 0);
        check_eq({tag, "_code"},  int'(err_code), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        // Good frame, ready held high: three consecutive transfers
        send_frame('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, EV_GOOD);
        check_eq("good_pulse", int'(frame_good), 1);
        for (int i = 0; i < 3; i++) begin
            check_eq("consec_valid", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        check_eq("after_last", int'(out_valid), 0);
        wait_drain(20);

        // Bad checksum
        send_frame('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A}, 0);
        wait_drain(20);

        // Length errors, then a 1-byte frame
        send_frame('{8'h7E, 8'h00}, 1);
        send_frame('{8'h7E, 8'h11}, 1);
        send_frame('{8'h7E, 8'h01, 8'h5A, 8'h5B}, EV_GOOD);
        wait_drain(20);

        // Timeout after partial payload
        send_frame('{8'h7E, 8'h02, 8'hAA}, -1);
        evq.push_back(2);
        k = 0;
        for (int i = 1; i <= T_CLKS + 10; i++) begin
            @(posedge clk); #1;
            if (frame_err) begin k = i; break; end
        end
        check_eq("timeout_lat", int'(k >= T_CLKS && k <= T_CLKS + 1), 1);
        wait_drain(5);
        send_frame('{8'h7E, 8'h01, 8'h33, 8'h34}, EV_GOOD);
        wait_drain(20);

        // Backpressure with an overrun byte during delivery
        send_frame('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, EV_GOOD);
        for (int j = 0; j < 20; j++) begin
            out_ready = j[0];
            if (j == 1) begin
                evq.push_back(3);
                in_valid = 1'b1;
                in_data  = 8'h55;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 8'h00;
            if (j > 1 && dq.size() == 0) break;
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Reset mid-payload discards the frame
        send_frame('{8'h7E, 8'h03, 8'h11}, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_valid", int'(out_valid), 0);
        send_frame('{8'h7E, 8'h01, 8'h00, 8'h01}, EV_GOOD);
        wait_drain(20);

        check_eq("dq_empty", dq.size(), 0);
        check_eq("evq_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter SOF, default 8'h7E: start-of-frame byte value.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 4096: idle clocks between accepted bytes before a frame aborts.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  single-cycle strobe, in_data holds a received byte; no backpressure.
REQ-007 SHALL have port in_data  input  8  received byte, sampled only when in_valid=1.
REQ-008 SHALL have port out_valid  output  1  payload byte available on out_data.
REQ-009 SHALL have port out_data  output  8  payload byte; 8'h00 when out_valid=0.
REQ-010 SHALL have port out_last  output  1  qualifies final payload byte of the frame; 0 when out_valid=0.
REQ-011 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-012 SHALL have port frame_good  output  1  one-cycle pulse, frame checksum passed.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse, frame or byte discarded.
REQ-014 SHALL have port err_code  output  2  valid with frame_err: 0 checksum, 1 length, 2 timeout, 3 overrun; 0 otherwise.

Function
REQ-015 SHALL implement states HUNT, LEN, PAYLOAD, CSUM, DELIVER; frame format SOF, LEN, LEN payload bytes, CSUM.
REQ-016 HUNT: in_valid with in_data==SOF -> LEN; any other byte silently ignored.
REQ-017 LEN: byte 1..MAX_LEN -> stored as length, running sum=byte, -> PAYLOAD; byte 0 or >MAX_LEN -> frame_err code 1, -> HUNT.
REQ-018 PAYLOAD: each byte written to internal buffer at index 0..LEN-1 and added to running sum mod 256; after LEN-th byte -> CSUM.
REQ-019 No escaping: SOF value in LEN, PAYLOAD or CSUM is treated as ordinary data.
REQ-020 CSUM: byte == running sum (8-bit, wraps) -> DELIVER; mismatch -> frame_err code 0, -> HUNT, buffer discarded.
REQ-021 Cycle after matching CSUM byte: frame_good=1 for one cycle and out_valid=1 with out_data=buffer[0].
REQ-022 DELIVER: out_data/out_last SHALL hold stable while out_valid & ~out_ready; each transfer advances index by one.
REQ-023 out_last=1 when index==LEN-1; cycle after last transfer out_valid=0, state HUNT.
REQ-024 With out_ready held 1, LEN bytes SHALL transfer in LEN consecutive cycles.
REQ-025 in_valid during DELIVER: byte dropped, frame_err code 3 pulse next cycle, delivery unaffected.
REQ-026 Timeout counter runs in LEN, PAYLOAD, CSUM; cleared on every in_valid and on entry from HUNT.
REQ-027 Counter reaching TIMEOUT_CLKS -> frame_err code 2 next cycle, -> HUNT; in_valid in same cycle wins (byte processed, counter cleared).
REQ-028 All error pulses SHALL occur the cycle after the offending byte or timeout; frame_good and frame_err never both 1.

Reset
REQ-029 reset SHALL force state HUNT, index/length/sum/timeout counter 0, and out_valid, out_data, out_last, frame_good, frame_err, err_code all 0 on the next edge.
REQ-030 reset mid-frame or mid-DELIVER SHALL discard buffer contents; no pulse or partial delivery follows.

Verification
REQ-031 Good frame: 7E 03 11 22 33 69, out_ready=1 -> frame_good pulse; out 11,22,33 on 3 consecutive cycles, out_last on 33.
REQ-032 Bad checksum: 7E 03 11 22 33 6A -> frame_err, err_code 0, out_valid never 1.
REQ-033 Length: 7E 00 -> err_code 1; 7E 11 (17>MAX_LEN) -> err_code 1; next 7E 01 5A 5B -> frame_good, out 5A last.
REQ-034 Timeout: 7E 02 AA then no in_valid for TIMEOUT_CLKS -> err_code 2, state HUNT; subsequent good frame accepted.
REQ-035 Backpressure/overrun: good 3-byte frame, out_ready toggled 1/0, byte 55 injected in DELIVER -> err_code 3, delivered bytes 11,22,33 intact and held stable while stalled.
REQ-036 Reset during PAYLOAD of 7E 03 11 -> all outputs 0; then 7E 01 00 01 -> frame_good, out 00 with out_last.
